bus_arbiter_16: RTL and testbench
=================================

# bus_arbiter_16

Round-robin arbiter that shares one 16-bit result bus among 16 requesters. It drives the 4-bit select of the existing `mux_16_1_16b` datapath and issues one-hot grants and a bus-valid qualifier. A consumer-side `ack` counts accepted words. Each grant is capped at a programmable burst length so no requester can starve the others.

## Interface
- `BURST_MAX`, default 4: max words accepted per grant, legal range 1..15.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 16: `req[i]` high means requester i has a word on mux input i.
- `ack` input 1: consumer accepts the current bus word; ignored when `bus_valid`=0.
- `gnt` output 16: one-hot registered grant, all zero when idle.
- `sel3`, `sel2`, `sel1`, `sel0` output 1 each: registered binary index of the owner, wired to the mux select.
- `bus_valid` output 1: bus carries a valid word this cycle.

## Operation
- State machine with two states.
  - IDLE: `gnt`=0, `bus_valid`=0, `sel` holds the last owner's index.
  - GRANT: one owner; `bus_valid` = `req[owner]` (combinational off the registered owner).
- Arbitration: rotated priority search starting at `ptr`. The first `i` in `ptr, ptr+1, …` (mod 16) with `req[i]`=1 wins. `ptr` wraps 15→0.
- IDLE→GRANT: any `req` high at an edge sets `gnt`, `sel` and `state` on that edge. `count` clears to 0.
- Transfer: a cycle with `bus_valid`=1 and `ack`=1. It increments `count`.
- Release in GRANT, when either condition holds:
  - `req[owner]`=0 (owner withdrew, no transfer this cycle), or
  - a transfer occurs with `count` = `BURST_MAX`-1.
- On release, in the same cycle:
  - `ptr` ← owner+1 mod 16.
  - Re-arbitrate from the new `ptr` using the current `req`.
  - A winner is registered on the next edge with no idle bubble and `count` cleared.
  - With no requests, go to IDLE.
- Single persistent requester: after a burst it is re-granted immediately. `gnt` stays high and `count` restarts.
- `BURST_MAX`=1 gives word-granular round robin.
- A transfer on a release cycle caused by burst limit counts. The owner may drop `req` in the cycle after its last ack.
- Reset mid-burst abandons the burst. No word is considered transferred after reset.

## Timing
- Reset values: `state`=IDLE, `gnt`=16'h0000, `sel3..sel0`=0, `bus_valid`=0, `ptr`=0, `count`=0.
- Request-to-grant latency: 1 cycle. `req` sampled high at edge n gives `gnt`/`sel` valid after edge n.
- Handover latency: 0 idle cycles. The new owner's `gnt` and `sel` update on the edge following the release cycle.
- `sel` and `gnt` change only on clock edges, so the mux output is stable for a full cycle.
- `bus_valid` may fall combinationally within a GRANT cycle if the owner drops `req`. The consumer samples `bus_valid` & `ack` at the edge.
- Max wait for any continuously requesting input: 15 × `BURST_MAX` transfers plus 15 handover cycles.

## Structure
- Shared package `arb_pkg`:
  - constants `NUM_REQ`=16 and `SEL_W`=4;
  - state encoding `ST_IDLE`=1'b0, `ST_GRANT`=1'b1.
- Sub-module `rr_pick16`: combinational rotated priority encoder.
  - Inputs: `req[15:0]`, `ptr[3:0]`.
  - Outputs: `any`, `idx[3:0]`.
- Top: state and `count` registers, `ptr` register, `gnt` decode from `idx`, and `sel` bits driven from the registered index. Instantiated beside `mux_16_1_16b`.

## Test plan
- Reset with `req`=16'hFFFF held: all outputs 0 during reset. First edge after deassert gives `gnt`=16'h0001, `sel`=0, `bus_valid`=1.
- `BURST_MAX`=4, `req`=16'h0005, `ack` always 1:
  - requester 0 gets 4 transfers;
  - `gnt` switches to 16'h0004 on the next edge, no bubble;
  - requester 2 gets 4 transfers, then back to 16'h0001.
- Wrap-around: owner 15 releases with `req`=16'h8002, so `ptr`=0 and `gnt`=16'h0002. A later release of 1 with `req`=16'h8000 grants 15.
- Withdrawal: owner 3 drops `req` after 2 acks. `bus_valid`=0 that cycle and `count` does not increment. Next edge grants the next requester, or goes IDLE with `gnt`=0 if `req`=0.
- `ack` stalls: owner 5 with `ack`=0 for 10 cycles keeps `gnt`=16'h0020 and `count`=0. `ack` while `bus_valid`=0 never increments `count`.
- Synchronous reset asserted mid-burst (`count`=2): next edge IDLE, `ptr`=0. After release from reset, `req`=16'h0030 grants 4 first.

Source files
------------

// File: rtl/bus_arbiter_16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin bus arbiter.
package arb_pkg;
    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/bus_arbiter_16_rr_pick16.sv
// Rotated priority encoder: first asserted request at or after i_ptr, wrapping mod 16.
module rr_pick16
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [SEL_W-1:0]   o_idx
);

    logic [SEL_W-1:0] w_cand;

    // Scan from the far end back toward i_ptr so the nearest hit is the last write.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = i_ptr;
        w_cand = i_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = i_ptr + SEL_W'(k);
            if (i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_16.sv
// Round-robin owner of the shared 16-bit result bus; drives the mux select,
// one-hot grants and a bus-valid qualifier, with bursts capped at BURST_MAX words.
module bus_arbiter_16
    import arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_ack,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_sel3,
    output logic               o_sel2,
    output logic               o_sel1,
    output logic               o_sel0,
    output logic               o_bus_valid
);

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_owner, w_owner_nxt;
    logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
    logic [3:0]         r_count, w_count_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;

    logic               w_bus_valid, w_xfer, w_last_word, w_release, w_any;
    logic [SEL_W-1:0]   w_pick_ptr, w_idx;
    logic [NUM_REQ-1:0] w_gnt_dec;

    assign w_bus_valid = (r_state == ST_GRANT) && i_req[r_owner];
    assign w_xfer      = w_bus_valid && i_ack;
    assign w_last_word = (r_count == 4'(BURST_MAX - 1));
    assign w_release   = (r_state == ST_GRANT) && (!i_req[r_owner] || (w_xfer && w_last_word));

    // On release the search already starts past the outgoing owner, so handover has no bubble.
    assign w_pick_ptr  = w_release ? (r_owner + 4'd1) : r_ptr;
    assign w_gnt_dec   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_idx;

    rr_pick16 u_pick (
        .i_req (i_req),
        .i_ptr (w_pick_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_idx;
                    w_count_nxt = 4'd0;
                    w_gnt_nxt   = w_gnt_dec;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt   = w_pick_ptr;
                    w_count_nxt = 4'd0;
                    if (w_any) begin
                        w_owner_nxt = w_idx;
                        w_gnt_nxt   = w_gnt_dec;
                    end else begin
                        // Owner index is kept so the mux select holds in idle.
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_xfer) begin
                    w_count_nxt = r_count + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_sel3      = r_owner[3];
    assign o_sel2      = r_owner[2];
    assign o_sel1      = r_owner[1];
    assign o_sel0      = r_owner[0];
    assign o_bus_valid = w_bus_valid;

endmodule

// File: tb/tb_bus_arbiter_16.sv
// Directed scenarios plus randomized traffic checked against a cycle-level
// round-robin reference model of the bus arbiter.
module tb_bus_arbiter_16;

    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ack;
    logic [15:0] req;
    logic [15:0] gnt;
    logic        s3, s2, s1, s0, bv;

    always #5 clk = ~clk;

    bus_arbiter_16 #(.BURST_MAX(BURST)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_ack       (ack),
        .o_gnt       (gnt),
        .o_sel3      (s3),
        .o_sel2      (s2),
        .o_sel1      (s1),
        .o_sel0      (s0),
        .o_bus_valid (bv)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = idle), last owner on the select, pointer, words in burst.
    int m_owner, m_last, m_ptr, m_cnt;
    int xfers[16];

    function automatic int pick(logic [15:0] r, int p);
        for (int k = 0; k < 16; k++)
            if (r[(p + k) % 16]) return (p + k) % 16;
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_xfers();
        for (int i = 0; i < 16; i++) xfers[i] = 0;
    endtask

    // Drive one cycle's inputs, check current outputs against the model, then advance the model.
    task automatic step(logic a_rst, logic [15:0] a_req, logic a_ack);
        logic [15:0] exp_gnt;
        logic        exp_bv, xfer, rel;
        logic [3:0]  sel_now;
        int          w;
        @(negedge clk);
        rst = a_rst;
        req = a_req;
        ack = a_ack;
        #1;
        exp_gnt = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
        exp_bv  = (m_owner >= 0) && a_req[m_owner];
        sel_now = {s3, s2, s1, s0};
        chk("gnt", gnt, exp_gnt);
        chk("sel", sel_now, m_last[3:0]);
        chk("bus_valid", bv, exp_bv);
        chk("count", dut.r_count, m_cnt);
        chk("ptr", dut.r_ptr, m_ptr);
        if (bv && a_ack && !a_rst) xfers[sel_now]++;

        if (a_rst) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            w = pick(a_req, m_ptr);
            if (w >= 0) begin m_owner = w; m_last = w; m_cnt = 0; end
        end else begin
            xfer = exp_bv && a_ack;
            rel  = !a_req[m_owner] || (xfer && m_cnt == BURST - 1);
            if (rel) begin
                m_ptr = (m_owner + 1) % 16;
                m_cnt = 0;
                w = pick(a_req, m_ptr);
                if (w >= 0) begin m_owner = w; m_last = w; end
                else m_owner = -1;
            end else if (xfer) begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 16'h0; ack = 1'b0;
        m_owner = -1; m_last = 0; m_ptr = 0; m_cnt = 0;
        clr_xfers();
        repeat (2) @(posedge clk);

        // Reset held with every requester asserted
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        chk("rst_gnt", gnt, 16'h0000);
        step(1'b0, 16'hFFFF, 1'b0);
        step(1'b0, 16'hFFFF, 1'b0);
        chk("rst_first_gnt", gnt, 16'h0001);
        chk("rst_first_bv", bv, 1'b1);

        // Two requesters alternate full bursts
        step(1'b1, 16'h0000, 1'b0);
        clr_xfers();
        step(1'b0, 16'h0005, 1'b1);
        for (int i = 0; i < BURST; i++) begin
            step(1'b0, 16'h0005, 1'b1);
            chk("burst_r0_gnt", gnt, 16'h0001);
        end
        for (int i = 0; i < BURST; i++) begin
            step(1'b0, 16'h0005, 1'b1);
            chk("burst_r2_gnt", gnt, 16'h0004);
        end
        chk("xfers_r0", xfers[0], BURST);
        chk("xfers_r2", xfers[2], BURST);
        step(1'b0, 16'h0005, 1'b1);
        chk("burst_back_r0", gnt, 16'h0001);

        // Pointer wrap-around 15 -> 0
        step(1'b1, 16'h0000, 1'b0);
        step(1'b0, 16'h8000, 1'b0);
        step(1'b0, 16'h8000, 1'b0);
        chk("wrap_own15", gnt, 16'h8000);
        for (int i = 0; i < BURST; i++) step(1'b0, 16'h8002, 1'b1);
        step(1'b0, 16'h8002, 1'b0);
        chk("wrap_gnt1", gnt, 16'h0002);
        chk("wrap_ptr0", dut.r_ptr, 4'd0);
        step(1'b0, 16'h8000, 1'b1);
        step(1'b0, 16'h8000, 1'b0);
        chk("wrap_gnt15", gnt, 16'h8000);

        // Owner withdraws mid-burst
        step(1'b1, 16'h0000, 1'b0);
        step(1'b0, 16'h0008, 1'b1);
        step(1'b0, 16'h0008, 1'b1);
        step(1'b0, 16'h0008, 1'b1);
        step(1'b0, 16'h0010, 1'b1);
        chk("wd_bv", bv, 1'b0);
        chk("wd_count", dut.r_count, 4'd2);
        step(1'b0, 16'h0010, 1'b0);
        chk("wd_next_gnt", gnt, 16'h0010);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        chk("wd_idle_gnt", gnt, 16'h0000);

        // Consumer stalls
        step(1'b1, 16'h0000, 1'b0);
        step(1'b0, 16'h0020, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0020, 1'b0);
            chk("stall_gnt", gnt, 16'h0020);
            chk("stall_count", dut.r_count, 4'd0);
        end
        step(1'b0, 16'h0000, 1'b1);
        chk("stall_drop_bv", bv, 1'b0);

        // Reset mid-burst
        step(1'b1, 16'h0000, 1'b0);
        step(1'b0, 16'h0001, 1'b1);
        step(1'b0, 16'h0001, 1'b1);
        step(1'b0, 16'h0001, 1'b1);
        step(1'b1, 16'h0001, 1'b1);
        chk("mid_count2", dut.r_count, 4'd2);
        step(1'b0, 16'h0030, 1'b0);
        chk("mid_idle_gnt", gnt, 16'h0000);
        chk("mid_ptr0", dut.r_ptr, 4'd0);
        step(1'b0, 16'h0030, 1'b0);
        chk("mid_gnt4", gnt, 16'h0010);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            r = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) r = 16'h0;
            step($urandom_range(0, 99) == 0, r, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
